// File: rtl/id_stage_pipe.sv
// Registered decode stage: regfile, control decode, RAW interlock and an ID/EXE register behind a valid/ready handshake.
// Optional feature: define ID_BYPASS_EN for a write-first WB->read bypass with no WB-stage hazard check.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  output logic            id_ready,
  input  logic            exe_ready,
  input  logic            flush,
  input  logic [4:0]      exe_dest,
  input  logic [4:0]      mem_dest,
  input  logic            exe_wb_en,
  input  logic            mem_wb_en,
  input  logic            WB_Write_Enable,
  input  logic [4:0]      WB_Dest,
  input  logic [XLEN-1:0] WB_Data,
  output logic            id_valid,
  output logic [4:0]      Dest,
  output logic [XLEN-1:0] Val1,
  output logic [XLEN-1:0] Val2,
  output logic [XLEN-1:0] Reg2,
  output logic [1:0]      Br_type,
  output logic [3:0]      EXE_CMD,
  output logic            MEM_R_EN,
  output logic            MEM_W_EN,
  output logic            WB_EN,
  output logic            IF_flush,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd3,  OP_AND  = 6'd5,
    OP_OR   = 6'd6,  OP_NOR  = 6'd7,  OP_XOR  = 6'd8,  OP_SLA  = 6'd9,
    OP_SLL  = 6'd10, OP_SRA  = 6'd11, OP_SRL  = 6'd12, OP_ADDI = 6'd32,
    OP_SUBI = 6'd33, OP_LD   = 6'd36, OP_ST   = 6'd37, OP_BEZ  = 6'd40,
    OP_BNE  = 6'd41, OP_JMP  = 6'd42
  } opcode_e;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic [1:0] br_type;
    logic       is_imm;
  } ctrl_t;

  logic [5:0]      opcode;
  logic [4:0]      dest, src1, src2;
  logic [15:0]     imm;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm_ext, rd1, rd2;
  logic            use_src2, hazard, slot_free, wb_we_ok;
  logic [XLEN-1:0] regs [32];

  assign opcode  = if_instr[31:26];
  assign dest    = if_instr[25:21];
  assign src1    = if_instr[20:16];
  assign src2    = if_instr[15:11];
  assign imm     = if_instr[15:0];
  assign imm_ext = {{(XLEN-16){imm[15]}}, imm};

  assign wb_we_ok  = WB_Write_Enable && (WB_Dest != 5'd0) && (32'(WB_Dest) < NREG);
  assign slot_free = !id_valid || exe_ready;
  assign id_ready  = flush || (slot_free && !hazard);
  assign IF_flush  = flush;

  // Unlisted opcodes decode as a NOP so an illegal word can never write back.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    ctrl = '0;
    case (opcode)
      OP_ADD:  ctrl = '{exe_cmd: 4'b0000, wb_en: 1'b1, default: '0};
      OP_SUB:  ctrl = '{exe_cmd: 4'b0010, wb_en: 1'b1, default: '0};
      OP_AND:  ctrl = '{exe_cmd: 4'b0100, wb_en: 1'b1, default: '0};
      OP_OR:   ctrl = '{exe_cmd: 4'b0101, wb_en: 1'b1, default: '0};
      OP_NOR:  ctrl = '{exe_cmd: 4'b0110, wb_en: 1'b1, default: '0};
      OP_XOR:  ctrl = '{exe_cmd: 4'b0111, wb_en: 1'b1, default: '0};
      OP_SLA,
      OP_SLL:  ctrl = '{exe_cmd: 4'b1000, wb_en: 1'b1, default: '0};
      OP_SRA:  ctrl = '{exe_cmd: 4'b1001, wb_en: 1'b1, default: '0};
      OP_SRL:  ctrl = '{exe_cmd: 4'b1010, wb_en: 1'b1, default: '0};
      OP_ADDI: ctrl = '{exe_cmd: 4'b0000, wb_en: 1'b1, is_imm: 1'b1, default: '0};
      OP_SUBI: ctrl = '{exe_cmd: 4'b0010, wb_en: 1'b1, is_imm: 1'b1, default: '0};
      OP_LD:   ctrl = '{exe_cmd: 4'b0000, mem_r_en: 1'b1, wb_en: 1'b1, is_imm: 1'b1, default: '0};
      OP_ST:   ctrl = '{exe_cmd: 4'b0000, mem_w_en: 1'b1, is_imm: 1'b1, default: '0};
      OP_BEZ:  ctrl = '{br_type: 2'b01, is_imm: 1'b1, default: '0};
      OP_BNE:  ctrl = '{br_type: 2'b10, is_imm: 1'b1, default: '0};
      OP_JMP:  ctrl = '{br_type: 2'b11, is_imm: 1'b1, default: '0};
      default: ctrl = '0;
    endcase
  end

  // Register reads; out-of-range indices and R0 read as zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (src1 != 5'd0 && 32'(src1) < NREG) rd1 = regs[src1];
    if (src2 != 5'd0 && 32'(src2) < NREG) rd2 = regs[src2];
`ifdef ID_BYPASS_EN
    if (wb_we_ok && src1 == WB_Dest) rd1 = WB_Data;
    if (wb_we_ok && src2 == WB_Dest) rd2 = WB_Data;
`endif
  end

  function automatic logic src_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic en);
    return en && (src != 5'd0) && (src == dst);
  endfunction

  assign use_src2 = !ctrl.is_imm || ctrl.mem_w_en;

  always_comb begin
    hazard = src_match(src1, exe_dest, exe_wb_en) || src_match(src1, mem_dest, mem_wb_en) ||
             (use_src2 && (src_match(src2, exe_dest, exe_wb_en) ||
                           src_match(src2, mem_dest, mem_wb_en)));
`ifndef ID_BYPASS_EN
    // Read-before-write regfile: a same-cycle WB match would read stale data.
    hazard = hazard || src_match(src1, WB_Dest, wb_we_ok) ||
             (use_src2 && src_match(src2, WB_Dest, wb_we_ok));
`endif
  end

  // NOTE: the regfile is reset explicitly because cleared registers on reset are architectural state here, not an init convenience.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we_ok) begin
      regs[WB_Dest] <= WB_Data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid  <= 1'b0;
      Dest      <= '0;
      Val1      <= '0;
      Val2      <= '0;
      Reg2      <= '0;
      Br_type   <= '0;
      EXE_CMD   <= '0;
      MEM_R_EN  <= 1'b0;
      MEM_W_EN  <= 1'b0;
      WB_EN     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (if_valid && hazard && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNTW'(1);

      if (slot_free && if_valid && !hazard && !flush) begin
        id_valid <= 1'b1;
        Dest     <= dest;
        Val1     <= rd1;
        Val2     <= ctrl.is_imm ? imm_ext : rd2;
        Reg2     <= rd2;
        Br_type  <= ctrl.br_type;
        EXE_CMD  <= ctrl.exe_cmd;
        MEM_R_EN <= ctrl.mem_r_en;
        MEM_W_EN <= ctrl.mem_w_en;
        WB_EN    <= ctrl.wb_en;
      end else if (flush || slot_free) begin
        // Flush or bubble: kill the slot; data fields are left as don't-care.
        id_valid <= 1'b0;
        Br_type  <= '0;
        EXE_CMD  <= '0;
        MEM_R_EN <= 1'b0;
        MEM_W_EN <= 1'b0;
        WB_EN    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe: reset, regfile, decode, hazards, back-pressure, flush, bypass.
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic            id_ready;
  logic            exe_ready;
  logic            flush;
  logic [4:0]      exe_dest, mem_dest;
  logic            exe_wb_en, mem_wb_en;
  logic            WB_Write_Enable;
  logic [4:0]      WB_Dest;
  logic [XLEN-1:0] WB_Data;
  logic            id_valid;
  logic [4:0]      Dest;
  logic [XLEN-1:0] Val1, Val2, Reg2;
  logic [1:0]      Br_type;
  logic [3:0]      EXE_CMD;
  logic            MEM_R_EN, MEM_W_EN, WB_EN;
  logic            IF_flush;
  logic [CNTW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
    .exe_ready(exe_ready), .flush(flush), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .WB_Write_Enable(WB_Write_Enable),
    .WB_Dest(WB_Dest), .WB_Data(WB_Data), .id_valid(id_valid), .Dest(Dest), .Val1(Val1),
    .Val2(Val2), .Reg2(Reg2), .Br_type(Br_type), .EXE_CMD(EXE_CMD), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .IF_flush(IF_flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_instr(input logic [5:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2);
    return {op, d, s1, s2, 11'd0};
  endfunction

  function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [15:0] im);
    return {op, d, s1, im};
  endfunction

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_instr = '0; exe_ready = 1'b1; flush = 1'b0;
    exe_dest = '0; mem_dest = '0; exe_wb_en = 1'b0; mem_wb_en = 1'b0;
    WB_Write_Enable = 1'b0; WB_Dest = '0; WB_Data = '0;

    // Reset held for two cycles
    tick(); tick();
    check("rst_id_valid", id_valid, 0);
    check("rst_exe_cmd", EXE_CMD, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b1;

    // Read R5 after release
    if_valid = 1'b1; if_instr = r_instr(6'd1, 5'd1, 5'd5, 5'd0);
    tick();
    check("r5_valid", id_valid, 1);
    check("r5_val1", Val1, 0);

    // WB write R3, no decode
    if_valid = 1'b0;
    WB_Write_Enable = 1'b1; WB_Dest = 5'd3; WB_Data = 32'hDEADBEEF;
    tick();
    check("bubble_no_if_valid", id_valid, 0);
    WB_Write_Enable = 1'b0;

    // ADD d2, r3, r0
    if_valid = 1'b1; if_instr = r_instr(6'd1, 5'd2, 5'd3, 5'd0);
    tick();
    check("r3_val1", Val1, 32'hDEADBEEF);
    check("add_wb_en", WB_EN, 1);
    check("add_dest", Dest, 2);

    // SUBI d2, r0, 0x8000
    if_instr = i_instr(6'd33, 5'd2, 5'd0, 16'h8000);
    tick();
    check("imm_sext_val2", Val2, 32'hFFFF8000);
    check("subi_exe_cmd", EXE_CMD, 4'b0010);
    check("subi_reg2", Reg2, 0);

    // EXE hazard on src2
    exe_dest = 5'd4; exe_wb_en = 1'b1;
    if_instr = r_instr(6'd1, 5'd5, 5'd0, 5'd4);
    #1 check("exe_haz_ready", id_ready, 0);
    tick();
    check("exe_haz_bubble", id_valid, 0);
    check("exe_haz_cnt", stall_cnt, 1);
    exe_wb_en = 1'b0;
    #1 check("haz_clear_ready", id_ready, 1);
    tick();
    check("haz_clear_load", id_valid, 1);
    check("haz_clear_dest", Dest, 5);

    // Back-pressure for three cycles
    exe_ready = 1'b0;
    if_instr = r_instr(6'd3, 5'd6, 5'd3, 5'd3);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", id_ready, 0);
      tick();
      check("bp_hold_dest", Dest, 5);
      check("bp_hold_valid", id_valid, 1);
      check("bp_hold_cmd", EXE_CMD, 0);
    end
    exe_ready = 1'b1;
    #1 check("bp_release_ready", id_ready, 1);
    tick();
    check("bp_next_dest", Dest, 6);
    check("bp_next_cmd", EXE_CMD, 4'b0010);
    check("bp_next_reg2", Reg2, 32'hDEADBEEF);
    check("bp_no_stall_count", stall_cnt, 1);

    // Flush while live and fetching
    flush = 1'b1;
    if_instr = r_instr(6'd1, 5'd9, 5'd3, 5'd0);
    #1 check("flush_if_flush", IF_flush, 1);
    check("flush_ready", id_ready, 1);
    tick();
    check("flush_valid", id_valid, 0);
    check("flush_wb_en", WB_EN, 0);
    flush = 1'b0;

    // Same-cycle WB write R7 and read
    WB_Write_Enable = 1'b1; WB_Dest = 5'd7; WB_Data = 32'h55;
    if_instr = r_instr(6'd1, 5'd8, 5'd7, 5'd0);
`ifdef ID_BYPASS_EN
    #1 check("bypass_ready", id_ready, 1);
    tick();
    check("bypass_valid", id_valid, 1);
    check("bypass_val1", Val1, 32'h55);
    check("bypass_no_stall", stall_cnt, 1);
    WB_Write_Enable = 1'b0;
`else
    #1 check("wb_haz_ready", id_ready, 0);
    tick();
    check("wb_haz_bubble", id_valid, 0);
    check("wb_haz_cnt", stall_cnt, 2);
    WB_Write_Enable = 1'b0;
    tick();
    check("wb_haz_valid", id_valid, 1);
    check("wb_haz_val1", Val1, 32'h55);
`endif

    // ST uses src2 (imm[15:11]=9) -> MEM hazard; ADDI with same field does not
    mem_dest = 5'd9; mem_wb_en = 1'b1;
    if_instr = i_instr(6'd37, 5'd0, 5'd0, 16'h4800);
    #1 check("st_src2_haz", id_ready, 0);
    if_instr = i_instr(6'd32, 5'd1, 5'd0, 16'h4800);
    #1 check("addi_src2_unused", id_ready, 1);
    mem_wb_en = 1'b0;

    // Index 0 is never a hazard
    exe_dest = 5'd0; exe_wb_en = 1'b1;
    if_instr = r_instr(6'd1, 5'd1, 5'd0, 5'd0);
    #1 check("r0_no_haz", id_ready, 1);
    exe_wb_en = 1'b0;
    tick();

    // Reset in the middle of a stall
    exe_dest = 5'd4; exe_wb_en = 1'b1;
    if_instr = r_instr(6'd1, 5'd5, 5'd0, 5'd4);
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_valid", id_valid, 0);
    check("rst_mid_cnt", stall_cnt, 0);
    rst = 1'b1; exe_wb_en = 1'b0;
    if_instr = r_instr(6'd1, 5'd2, 5'd3, 5'd0);
    #1 check("rst_mid_ready", id_ready, 1);
    tick();
    check("rst_regfile_cleared", Val1, 0);
    check("rst_mid_load", id_valid, 1);

    // Stall counter saturation
    exe_wb_en = 1'b1;
    if_instr = r_instr(6'd1, 5'd5, 5'd0, 5'd4);
    for (int i = 0; i < 20; i++) tick();
    check("cnt_saturate", stall_cnt, 4'hF);
    check("cnt_sat_bubble", id_valid, 0);
    exe_wb_en = 1'b0; if_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, registered successor of the decode stage. It contains the register file, immediate extension, `Control_unit` decode and a load-use/RAW hazard interlock. It drives an ID/EXE pipeline register through a valid/ready handshake, sitting between the IF stage and EXE with stall, bubble and flush support. Writeback arrives from the WB stage on the `WB_*` ports.

## Interface
- `XLEN`, 32: datapath width, ≥32; immediates sign-extend from 16 to `XLEN`.
- `NREG`, 32: architectural registers, 2..32; index ≥`NREG` reads 0, writes ignored.
- `CNTW`, 16: width of the stall counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `if_valid`  in  1  `if_instr` is valid.
- `if_instr`  in  32  instruction: opcode[31:26], dest[25:21], src1[20:16], src2[15:11], imm[15:0].
- `id_ready`  out  1  decode accepts `if_instr` this cycle.
- `exe_ready`  in  1  EXE accepts the ID/EXE register this cycle.
- `flush`  in  1  taken branch; kill the decode and ID/EXE contents.
- `exe_dest`, `mem_dest`  in  5  destinations in EXE/MEM.
- `exe_wb_en`, `mem_wb_en`  in  1  those destinations will be written.
- `WB_Write_Enable`  in  1  register write strobe.
- `WB_Dest`  in  5  write index.
- `WB_Data`  in  `XLEN`  write data.
- `id_valid`  out  1  ID/EXE register holds a live instruction.
- `Dest`  out  5  registered destination index.
- `Val1`, `Val2`, `Reg2`  out  `XLEN`  registered src1 value, ALU operand 2 (imm or src2), src2 value.
- `Br_type`  out  2  registered branch type.
- `EXE_CMD`  out  4  registered execute command.
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN`  out  1  registered control bits.
- `IF_flush`  out  1  equals `flush`; combinational pass-through to IF.
- `stall_cnt`  out  `CNTW`  saturating count of hazard-stall cycles.

## Operation
- **Register file:** `NREG`×`XLEN`. All entries clear on reset. Written at the clock edge when `WB_Write_Enable` is set and 0<`WB_Dest`<`NREG`. R0 always reads 0.
- **Decode:** `Control_unit` maps opcode to `EXE_CMD`, `MEM_R_EN`, `MEM_W_EN`, `WB_EN`, `Br_type` and `is_imm`. `Val2 = is_imm ? sext(imm) : R[src2]`; `Reg2 = R[src2]`.
- **Source use:**
  - src1 is used by every instruction.
  - src2 is used when `!is_imm` or `MEM_W_EN`.
  - Index 0 is never a hazard.
- **Hazard:** a used source equals `exe_dest` with `exe_wb_en`, or `mem_dest` with `mem_wb_en`. Without the bypass, a match on `WB_Dest` with `WB_Write_Enable` is also a hazard.
- **Slot free:** `slot_free = !id_valid | exe_ready`.
- **Ready:** `id_ready = flush | (slot_free & !hazard)`.
- **Per-cycle update, in priority order:**
  1. `!rst`: `id_valid`=0, all registered outputs 0, `stall_cnt`=0, regfile cleared.
  2. `flush`: `id_valid`←0 and control outputs←0. Any `if_instr` is consumed and discarded.
  3. `slot_free & if_valid & !hazard`: load the decoded instruction, `id_valid`←1.
  4. `slot_free & (hazard | !if_valid)`: insert a bubble (`id_valid`←0, control outputs←0, data outputs don't-care).
  5. Otherwise (`!slot_free`): hold all outputs.
- **Stall counter:** `stall_cnt` increments on cycles with `if_valid & hazard & !flush` and saturates at all-ones.

## Timing
- Latency: accepted at edge N, visible on outputs after edge N (1 cycle).
- Throughput: one instruction per cycle with no hazard and `exe_ready` held high.
- Regfile write lands at the edge. A read of the same index in the same cycle:
  - with the bypass: returns `WB_Data`;
  - without it: returns the old value, so it is stalled instead.
- Back-pressure: `id_ready` is low while `!slot_free` or a hazard is present. Outputs stay stable while `id_valid & !exe_ready`.
- `flush` together with a valid `exe_ready` still clears `id_valid` at the next edge.
- Reset mid-stall: everything is clear at the next edge and `id_ready`=1 the cycle after reset is released.

## Configuration
- `ID_BYPASS_EN` defined: same-cycle WB→read bypass (write-first) on both read ports, and no WB-stage hazard check.
- Undefined: read-before-write regfile, and a WB destination match stalls for one cycle.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles → `id_valid`=0, `EXE_CMD`=0, `stall_cnt`=0; reading R5 after release returns 0.
- **Write then read:** write R3=0xDEADBEEF via WB, then decode with src1=3 → `Val1`=0xDEADBEEF one cycle later. An imm instruction with imm=0x8000 → `Val2`=0xFFFF8000.
- **Hazard:** `exe_dest`=4 with `exe_wb_en`=1, decode src2=4 non-imm → `id_ready`=0, bubble (`id_valid`=0), `stall_cnt`=1. Clear the hazard → loads next cycle.
- **Back-pressure:** `id_valid`=1 with `exe_ready`=0 for 3 cycles → outputs constant and `id_ready`=0. Raise `exe_ready` → next instruction loaded.
- **Flush:** assert `flush` while `id_valid`=1 and `if_valid`=1 → `id_valid`=0 next cycle, `IF_flush`=1 the same cycle.
- **Bypass:** WB writes R7=0x55 in the same cycle as decode src1=7 → with `ID_BYPASS_EN`, `Val1`=0x55 and no stall; without it, one stall cycle, then `Val1`=0x55.
